// File: rtl/dcache_pkg.sv
// Shared definitions for the two-requester dcache arbiter: bus width default,
// FSM state encoding and requester ids.
package dcache_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic ID_R0 = 1'b0;
    localparam logic ID_R1 = 1'b1;

endpackage

// File: rtl/dcache_arb_rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the requester that was not
// granted last wins.
module rr_arb2
    import dcache_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt_id,
    output logic gnt_valid
);

    // Grant selection
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_id    = ID_R0;
        if (req0 && req1) begin
            gnt_id = ~last_grant;
        end else if (req1) begin
            gnt_id = ID_R1;
        end else begin
            gnt_id = ID_R0;
        end
    end

endmodule

// File: rtl/dcache_arb.sv
// Arbitrates two single-outstanding requesters onto one dcache port using a
// three-state IDLE/ISSUE/RESP sequence.
module dcache_arb
    import dcache_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             r0_req,
    input  logic             r0_we,
    input  logic [WIDTH-1:0] r0_addr,
    input  logic [WIDTH-1:0] r0_wdata,
    output logic             r0_ack,
    output logic [WIDTH-1:0] r0_rdata,
    input  logic             r1_req,
    input  logic             r1_we,
    input  logic [WIDTH-1:0] r1_addr,
    input  logic [WIDTH-1:0] r1_wdata,
    output logic             r1_ack,
    output logic [WIDTH-1:0] r1_rdata,
    output logic [WIDTH-1:0] dc_address,
    output logic [WIDTH-1:0] dc_data_in,
    output logic             dc_read,
    output logic             dc_write,
    input  logic [WIDTH-1:0] dc_data_out,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~{{(WIDTH-2){1'b0}}, 2'b11};

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             gnt_q, gnt_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] r0_rdata_q, r0_rdata_d;
    logic [WIDTH-1:0] r1_rdata_q, r1_rdata_d;
    logic             arb_id_s;
    logic             arb_valid_s;

    rr_arb2 u_arb (
        .req0       (r0_req),
        .req1       (r1_req),
        .last_grant (last_grant_q),
        .gnt_id     (arb_id_s),
        .gnt_valid  (arb_valid_s)
    );

    // Next-state, request latching and read-data capture
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        r0_rdata_d   = r0_rdata_q;
        r1_rdata_d   = r1_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid_s) begin
                    gnt_d   = arb_id_s;
                    we_d    = (arb_id_s == ID_R1) ? r1_we    : r0_we;
                    addr_d  = (arb_id_s == ID_R1) ? r1_addr  : r0_addr;
                    wdata_d = (arb_id_s == ID_R1) ? r1_wdata : r0_wdata;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // dcache read data is valid at the end of the strobe cycle
                if (!we_q && gnt_q == ID_R1) begin
                    r1_rdata_d = dc_data_out;
                end else if (!we_q) begin
                    r0_rdata_d = dc_data_out;
                end else begin
                    r0_rdata_d = r0_rdata_q;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                last_grant_d = gnt_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched-transaction registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            last_grant_q <= ID_R1;
            gnt_q        <= ID_R0;
            we_q         <= 1'b0;
            addr_q       <= {WIDTH{1'b0}};
            wdata_q      <= {WIDTH{1'b0}};
            r0_rdata_q   <= {WIDTH{1'b0}};
            r1_rdata_q   <= {WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            r0_rdata_q   <= r0_rdata_d;
            r1_rdata_q   <= r1_rdata_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign dc_read    = (state_q == ST_ISSUE) && !we_q;
    assign dc_write   = (state_q == ST_ISSUE) && we_q;
    assign dc_address = addr_q & ALIGN_MASK;
    assign dc_data_in = wdata_q;
    assign r0_ack     = (state_q == ST_RESP) && (gnt_q == ID_R0);
    assign r1_ack     = (state_q == ST_RESP) && (gnt_q == ID_R1);
    assign r0_rdata   = r0_rdata_q;
    assign r1_rdata   = r1_rdata_q;

endmodule

// File: tb/tb_dcache_arb.sv
// Directed bench for dcache_arb with a small word-addressed dcache model.
module tb_dcache_arb;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        r0_req = 1'b0, r0_we = 1'b0;
    logic [31:0] r0_addr = 32'd0, r0_wdata = 32'd0;
    logic        r0_ack;
    logic [31:0] r0_rdata;
    logic        r1_req = 1'b0, r1_we = 1'b0;
    logic [31:0] r1_addr = 32'd0, r1_wdata = 32'd0;
    logic        r1_ack;
    logic [31:0] r1_rdata;
    logic [31:0] dc_address, dc_data_in, dc_data_out;
    logic        dc_read, dc_write, busy;

    int n_run  = 0;
    int n_fail = 0;

    logic [31:0] mem [0:15];

    always #5 CLK = ~CLK;

    assign dc_data_out = mem[dc_address[5:2]];

    always @(posedge CLK) begin
        if (dc_write) mem[dc_address[5:2]] <= dc_data_in;
    end

    dcache_arb #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_rdata(r1_rdata),
        .dc_address(dc_address), .dc_data_in(dc_data_in),
        .dc_read(dc_read), .dc_write(dc_write),
        .dc_data_out(dc_data_out), .busy(busy)
    );

    task automatic test_reset();
        @(negedge CLK);
        n_run++;
        if ({busy, dc_read, dc_write, r0_ack, r1_ack} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {busy, dc_read, dc_write, r0_ack, r1_ack});
        end
        n_run++;
        if ({dc_address, dc_data_in, r0_rdata, r1_rdata} !== 128'd0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h %h want all zero", dc_address, dc_data_in, r0_rdata, r1_rdata);
        end
        RST = 1'b0;
    endtask

    task automatic test_write_read();
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'd4; r0_wdata = 32'h11;
        @(negedge CLK);
        n_run++;
        if ({dc_write, dc_read, busy} !== 3'b101 || dc_address !== 32'd4 || dc_data_in !== 32'h11) begin
            n_fail++; $display("FAIL wr_issue: got w%b r%b b%b a=%h d=%h want w1 r0 b1 a=4 d=11", dc_write, dc_read, busy, dc_address, dc_data_in);
        end
        @(negedge CLK);
        n_run++;
        if ({r0_ack, r1_ack, dc_write} !== 3'b100) begin
            n_fail++; $display("FAIL wr_ack: got %b want 100", {r0_ack, r1_ack, dc_write});
        end
        r0_req = 1'b0;
        @(negedge CLK);
        n_run++;
        if ({busy, r0_ack} !== 2'b00) begin
            n_fail++; $display("FAIL wr_idle: got %b want 00", {busy, r0_ack});
        end
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'd4;
        @(negedge CLK);
        n_run++;
        if ({dc_read, dc_write} !== 2'b10 || dc_address !== 32'd4) begin
            n_fail++; $display("FAIL rd_issue: got r%b w%b a=%h want r1 w0 a=4", dc_read, dc_write, dc_address);
        end
        @(negedge CLK);
        n_run++;
        if (r0_ack !== 1'b1 || r0_rdata !== 32'h11) begin
            n_fail++; $display("FAIL rd_ack: got ack=%b data=%h want ack=1 data=11", r0_ack, r0_rdata);
        end
        r0_req = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_tie();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'd8; r0_wdata = 32'h12;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'd8;
        @(negedge CLK);
        n_run++;
        if (dc_write !== 1'b1 || dc_address !== 32'd8) begin
            n_fail++; $display("FAIL tie_first: got w=%b a=%h want w=1 a=8", dc_write, dc_address);
        end
        @(negedge CLK);
        n_run++;
        if ({r0_ack, r1_ack} !== 2'b10) begin
            n_fail++; $display("FAIL tie_ack0: got %b want 10", {r0_ack, r1_ack});
        end
        r0_req = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        n_run++;
        if (dc_read !== 1'b1 || dc_address !== 32'd8) begin
            n_fail++; $display("FAIL tie_second: got r=%b a=%h want r=1 a=8", dc_read, dc_address);
        end
        @(negedge CLK);
        n_run++;
        if ({r0_ack, r1_ack} !== 2'b01 || r1_rdata !== 32'h12) begin
            n_fail++; $display("FAIL tie_ack1: got %b data=%h want 01 data=12", {r0_ack, r1_ack}, r1_rdata);
        end
        r1_req = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_alternate();
        int bad;
        bad = 0;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'd4;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'd8;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (dc_read !== 1'b1 || dc_address !== ((k % 2 == 0) ? 32'd4 : 32'd8)) bad++;
            @(negedge CLK);
            if (k % 2 == 0) begin
                if ({r0_ack, r1_ack} !== 2'b10 || r0_rdata !== 32'h11) bad++;
            end else begin
                if ({r0_ack, r1_ack} !== 2'b01 || r1_rdata !== 32'h12) bad++;
            end
            if (k == 5) begin
                r0_req = 1'b0; r1_req = 1'b0;
            end
            @(negedge CLK);
            if (busy !== 1'b0) bad++;
        end
        n_run++;
        if (bad != 0) begin
            n_fail++; $display("FAIL alternate: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_addr_align();
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'd7;
        @(negedge CLK);
        n_run++;
        if (dc_address !== 32'd4 || dc_read !== 1'b1) begin
            n_fail++; $display("FAIL align: got a=%h r=%b want a=4 r=1", dc_address, dc_read);
        end
        @(negedge CLK);
        n_run++;
        if (r1_ack !== 1'b1 || r1_rdata !== 32'h11) begin
            n_fail++; $display("FAIL align_data: got ack=%b data=%h want ack=1 data=11", r1_ack, r1_rdata);
        end
        r1_req = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_write_keeps_rdata();
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'd12; r1_wdata = 32'h33;
        @(negedge CLK);
        r1_req = 1'b0;
        @(negedge CLK);
        n_run++;
        if (r1_ack !== 1'b1 || r1_rdata !== 32'h11) begin
            n_fail++; $display("FAIL wr_keep: got ack=%b data=%h want ack=1 data=11", r1_ack, r1_rdata);
        end
        @(negedge CLK);
        n_run++;
        if ({busy, r1_ack} !== 2'b00) begin
            n_fail++; $display("FAIL drop_idle: got %b want 00", {busy, r1_ack});
        end
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'd12;
        @(negedge CLK);
        @(negedge CLK);
        n_run++;
        if (r0_ack !== 1'b1 || r0_rdata !== 32'h33) begin
            n_fail++; $display("FAIL wr_readback: got ack=%b data=%h want ack=1 data=33", r0_ack, r0_rdata);
        end
        r0_req = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset_abort();
        int acks;
        acks = 0;
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'd0; r0_wdata = 32'h55;
        @(negedge CLK);
        n_run++;
        if (dc_write !== 1'b1) begin
            n_fail++; $display("FAIL abort_pre: got w=%b want 1", dc_write);
        end
        r0_req = 1'b0;
        #2 RST = 1'b1;
        #1;
        n_run++;
        if ({dc_write, busy} !== 2'b00) begin
            n_fail++; $display("FAIL abort_drop: got w%b b%b want w0 b0", dc_write, busy);
        end
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (r0_ack !== 1'b0 || busy !== 1'b0) acks++;
        end
        n_run++;
        if (acks != 0) begin
            n_fail++; $display("FAIL abort_noack: got %0d active cycles want 0", acks);
        end
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'd4;
        @(negedge CLK);
        @(negedge CLK);
        n_run++;
        if (r0_ack !== 1'b1 || r0_rdata !== 32'h11) begin
            n_fail++; $display("FAIL abort_after: got ack=%b data=%h want ack=1 data=11", r0_ack, r0_rdata);
        end
        r0_req = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        test_reset();
        test_write_read();
        test_tie();
        test_alternate();
        test_addr_align();
        test_write_keeps_rdata();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_arb.md
DCACHE_ARB -- requirements
Module: dcache_arb

Interface
REQ-001 Parameter WIDTH, default 32: width of address and data buses.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 r0_req  input  1  requester 0 transaction request; held until r0_ack.
REQ-005 r0_we  input  1  requester 0: 1 = write, 0 = read.
REQ-006 r0_addr  input  WIDTH  requester 0 byte address.
REQ-007 r0_wdata  input  WIDTH  requester 0 write data.
REQ-008 r0_ack  output  1  requester 0 completion pulse, one cycle.
REQ-009 r0_rdata  output  WIDTH  requester 0 read data, valid while r0_ack high after a read.
REQ-010 r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rdata: same directions, widths, meanings for requester 1.
REQ-011 dc_address  output  WIDTH  dcache address.
REQ-012 dc_data_in  output  WIDTH  dcache write data.
REQ-013 dc_read  output  1  dcache read strobe.
REQ-014 dc_write  output  1  dcache write strobe.
REQ-015 dc_data_out  input  WIDTH  dcache read data, valid at end of the cycle in which dc_read is high.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states IDLE, ISSUE, RESP; reset state IDLE.
REQ-018 IDLE: no req -> stay; any req -> latch winner's we/addr/wdata and grant id, go to ISSUE.
REQ-019 Both requesting in IDLE -> grant requester not granted last; last_grant resets to 1, so r0 wins the first tie.
REQ-020 ISSUE: dc_read = !we, dc_write = we, exactly one cycle; always -> RESP.
REQ-021 dc_address = latched addr with bits [1:0] forced to 0; dc_data_in = latched wdata.
REQ-022 Reads: dc_data_out captured at end of ISSUE into the granted requester's rdata register.
REQ-023 RESP: ack of granted requester high one cycle; other ack low; always -> IDLE; last_grant updated.
REQ-024 Latency: req first seen in IDLE cycle N -> strobe cycle N+1 -> ack cycle N+2; next grant earliest cycle N+3.
REQ-025 dc_read and dc_write never both high; at most one ack high per cycle; strobes low outside ISSUE.
REQ-026 Write acks leave that requester's rdata unchanged.
REQ-027 rN_rdata holds its value until the next read completion for that requester.
REQ-028 req dropped after grant: transaction completes; ack still pulses.
REQ-029 req inputs are ignored in ISSUE and RESP; a new request still held after RESP is arbitrated in the following IDLE.
REQ-030 All outputs are registered or decoded from state and latched registers only; no combinational path from rN_* inputs to outputs.

Reset
REQ-031 RST high forces IDLE immediately, independent of CLK.
REQ-032 Reset values: dc_read = dc_write = 0, dc_address = dc_data_in = 0, r0_ack = r1_ack = 0, r0_rdata = r1_rdata = 0, busy = 0, last_grant = 1.
REQ-033 Reset during ISSUE or RESP aborts the transaction: strobes drop at once and no ack is issued after release.
REQ-034 The first arbitration occurs in the first IDLE cycle after RST deasserts.

Structure
REQ-035 Package dcache_pkg holds WIDTH default, FSM state encoding, and requester-id constants.
REQ-036 Sub-module rr_arb2 implements the combinational 2-way round-robin pick from (req0, req1, last_grant) and returns grant id and valid.
REQ-037 Requester ports are kept in individual signals so the block drops in beside the existing dcache port list.

Verification
REQ-038 r0 write addr 4, data 0x11 -> dc_write one cycle with dc_address 4, dc_data_in 0x11; r0_ack 2 cycles after request.
REQ-039 Then r0 read addr 4 -> dc_read one cycle; r0_ack with r0_rdata 0x11.
REQ-040 r0 and r1 request in the same cycle after reset (r0 write addr 8 data 0x12, r1 read addr 8) -> r0 served first, r1 served starting 3 cycles later with r1_rdata 0x12.
REQ-041 Both requesters held continuously for 6 transactions -> grants alternate r0, r1, r0, r1, r0, r1; 3 cycles per transaction.
REQ-042 r1 read addr 7 -> dc_address 4.
REQ-043 RST pulsed during ISSUE of a write -> dc_write drops immediately, no r0_ack, busy 0; a new request after release completes normally.
